imm_gen_pipe: RTL

- Pipelined, parametrised immediate generator for the decode stage of the miniRV core.
- Takes a raw 32-bit instruction and an immediate-format select, and produces a fully sign- or zero-extended XLEN-bit immediate.
- Output is registered behind a valid/ready handshake with a 2-entry skid buffer, so decode can stall without losing data and without a combinational ready path.
- Supports flush for branch redirect, and flags illegal format selects.

---
 rtl/imm_pkg.sv | 27 ++
 rtl/imm_extract.sv | 63 ++++++
 rtl/imm_gen_pipe.sv | 136 +++++++++++++
 3 files changed

// File: rtl/imm_pkg.sv
`default_nettype none
// ============================================================================
// Module   : imm_pkg
// Purpose  : Shared definitions for the miniRV immediate generator: the
//            immediate-format select encodings and the XLEN legality check.
// Ports    : none (package)
// Revision : 1.0 - initial release
// ============================================================================
package imm_pkg;

  // Immediate-format select encodings (in_op)
  localparam logic [2:0] IMM_I     = 3'b000;
  localparam logic [2:0] IMM_S     = 3'b001;
  localparam logic [2:0] IMM_B     = 3'b010;
  localparam logic [2:0] IMM_U     = 3'b011;
  localparam logic [2:0] IMM_J     = 3'b100;
  localparam logic [2:0] IMM_SHAMT = 3'b101;
  localparam logic [2:0] IMM_ZIMM  = 3'b110;
  localparam logic [2:0] IMM_ILL   = 3'b111;

  // Only RV32 and RV64 datapaths are meaningful for this generator.
  function automatic bit xlen_legal(input int unsigned xlen);
    return (xlen == 32) || (xlen == 64);
  endfunction

endpackage
`default_nettype wire

// File: rtl/imm_extract.sv
`default_nettype none
// ============================================================================
// Module   : imm_extract
// Purpose  : Purely combinational extraction and sign/zero extension of a
//            RISC-V immediate from a raw instruction word. Shared with the
//            single-cycle core.
// Ports    : instr_i [31:0]     raw instruction word
//            op_i    [2:0]      format select (imm_pkg::IMM_*)
//            imm_o   [XLEN-1:0] extended immediate (0 for illegal select)
//            err_o              illegal format select
// Revision : 1.0 - initial release
// ============================================================================
module imm_extract
  import imm_pkg::*;
#(
  parameter int unsigned XLEN = 32
) (
  input  logic [31:0]     instr_i,
  input  logic [2:0]      op_i,
  output logic [XLEN-1:0] imm_o,
  output logic            err_o
);

  if (!xlen_legal(XLEN)) begin : g_xlen_bad
    $error("imm_extract: XLEN must be 32 or 64");
  end

  logic        w_sign;
  logic [31:0] w_raw;
  logic        w_unused_opcode;

  assign w_sign          = instr_i[31];
  // Opcode field never contributes to an immediate.
  assign w_unused_opcode = ^instr_i[6:0];

  // Every format is first built as a 32-bit value whose bit 31 already
  // carries the correct extension bit (sign for I/S/B/U/J, zero for
  // SHAMT/ZIMM), so a single signed widening covers XLEN=64.
  always_comb begin
    w_raw = '0;
    err_o = 1'b0;
    case (op_i)
      IMM_I:     w_raw = {{20{w_sign}}, instr_i[31:20]};
      IMM_S:     w_raw = {{20{w_sign}}, instr_i[31:25], instr_i[11:7]};
      IMM_B:     w_raw = {{19{w_sign}}, instr_i[31], instr_i[7],
                          instr_i[30:25], instr_i[11:8], 1'b0};
      IMM_U:     w_raw = {instr_i[31:12], 12'b0};
      IMM_J:     w_raw = {{11{w_sign}}, instr_i[31], instr_i[19:12],
                          instr_i[20], instr_i[30:21], 1'b0};
      IMM_SHAMT: w_raw = (XLEN == 64) ? {26'b0, instr_i[25:20]}
                                      : {27'b0, instr_i[24:20]};
      IMM_ZIMM:  w_raw = {27'b0, instr_i[19:15]};
      default: begin
        w_raw = '0;
        err_o = 1'b1;
      end
    endcase
  end

  assign imm_o = XLEN'($signed(w_raw));

endmodule
`default_nettype wire

// File: rtl/imm_gen_pipe.sv
`default_nettype none
// ============================================================================
// Module   : imm_gen_pipe
// Purpose  : Pipelined immediate generator for the miniRV decode stage.
//            Immediate is formed combinationally, then held in an output
//            register backed by one skid register behind valid/ready.
// Ports    : clk, rst_n (async, active low), flush (sync kill)
//            in_valid / in_ready / in_instr[31:0] / in_op[2:0] / in_tag
//            out_valid / out_ready / out_imm[XLEN-1:0] / out_tag / out_err
// Revision : 1.0 - initial release
// ============================================================================
module imm_gen_pipe
  import imm_pkg::*;
#(
  parameter int unsigned XLEN  = 32,
  parameter int unsigned TAG_W = 5
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             flush,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [31:0]      in_instr,
  input  logic [2:0]       in_op,
  input  logic [TAG_W-1:0] in_tag,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [XLEN-1:0]  out_imm,
  output logic [TAG_W-1:0] out_tag,
  output logic             out_err
);

  logic [XLEN-1:0]  w_ext_imm;
  logic             w_ext_err;
  logic             w_accept;
  logic             w_out_free;

  logic             in_ready_q,  in_ready_d;
  logic             out_valid_q, out_valid_d;
  logic [XLEN-1:0]  out_imm_q,   out_imm_d;
  logic [TAG_W-1:0] out_tag_q,   out_tag_d;
  logic             out_err_q,   out_err_d;
  logic             skid_valid_q, skid_valid_d;
  logic [XLEN-1:0]  skid_imm_q,   skid_imm_d;
  logic [TAG_W-1:0] skid_tag_q,   skid_tag_d;
  logic             skid_err_q,   skid_err_d;

  imm_extract #(
    .XLEN (XLEN)
  ) u_extract (
    .instr_i (in_instr),
    .op_i    (in_op),
    .imm_o   (w_ext_imm),
    .err_o   (w_ext_err)
  );

  // A request offered during flush is dropped.
  assign w_accept   = in_valid & in_ready_q & ~flush;
  // Output register can take a new entry if empty or being consumed now.
  assign w_out_free = ~out_valid_q | out_ready;

  always_comb begin
    out_valid_d  = out_valid_q;
    out_imm_d    = out_imm_q;
    out_tag_d    = out_tag_q;
    out_err_d    = out_err_q;
    skid_valid_d = skid_valid_q;
    skid_imm_d   = skid_imm_q;
    skid_tag_d   = skid_tag_q;
    skid_err_d   = skid_err_q;

    if (flush) begin
      // Payloads are left stale; only the valid bits are killed.
      out_valid_d  = 1'b0;
      skid_valid_d = 1'b0;
    end else if (w_out_free) begin
      if (skid_valid_q) begin
        // in_ready is low whenever the skid is full, so no new entry can
        // compete with the skid for the output slot.
        out_valid_d  = 1'b1;
        out_imm_d    = skid_imm_q;
        out_tag_d    = skid_tag_q;
        out_err_d    = skid_err_q;
        skid_valid_d = 1'b0;
      end else if (w_accept) begin
        out_valid_d = 1'b1;
        out_imm_d   = w_ext_imm;
        out_tag_d   = in_tag;
        out_err_d   = w_ext_err;
      end else begin
        out_valid_d = 1'b0;
      end
    end else if (w_accept) begin
      skid_valid_d = 1'b1;
      skid_imm_d   = w_ext_imm;
      skid_tag_d   = in_tag;
      skid_err_d   = w_ext_err;
    end

    // Registered copy of !skid_valid keeps in_ready free of any path from
    // out_ready.
    in_ready_d = ~skid_valid_d;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      in_ready_q   <= 1'b1;
      out_valid_q  <= 1'b0;
      out_imm_q    <= '0;
      out_tag_q    <= '0;
      out_err_q    <= 1'b0;
      skid_valid_q <= 1'b0;
      skid_imm_q   <= '0;
      skid_tag_q   <= '0;
      skid_err_q   <= 1'b0;
    end else begin
      in_ready_q   <= in_ready_d;
      out_valid_q  <= out_valid_d;
      out_imm_q    <= out_imm_d;
      out_tag_q    <= out_tag_d;
      out_err_q    <= out_err_d;
      skid_valid_q <= skid_valid_d;
      skid_imm_q   <= skid_imm_d;
      skid_tag_q   <= skid_tag_d;
      skid_err_q   <= skid_err_d;
    end
  end

  assign in_ready  = in_ready_q;
  assign out_valid = out_valid_q;
  assign out_imm   = out_imm_q;
  assign out_tag   = out_tag_q;
  assign out_err   = out_err_q;

endmodule
`default_nettype wire
